addsub_sched_ctrl: RTL and testbench

- Multi-cycle, resource-shared implementation of a small scheduled dataflow graph: one shared add/sub unit plus one signed comparator, sequenced by an FSM controller.
- Serves as the hand-written golden model for the scheduled (FSMD) flow. It sits beside the combinational/registered circuit models and is checked in the same clk_gen/rst_gen/serror_monitor style bench.
- Computed function:
  - d=a+b; e=a+c; f=a-b; g=(d>e)
  - z = g ? d : e
  - x = f-c

---
 rtl/addsub_sched_ctrl_pkg.sv | 19 +
 rtl/addsub_sched_ctrl_shared_addsub.sv | 14 +
 rtl/addsub_sched_ctrl.sv | 122 ++++++++++++
 tb/tb_addsub_sched_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/addsub_sched_ctrl_pkg.sv
// Shared definitions for the scheduled add/sub datapath: state encoding,
// shared-unit op select codes and the default data width.
package addsub_sched_ctrl_pkg;

  localparam int DATAWIDTH_DEFAULT = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_S4    = 3'd4,
    ST_FINAL = 3'd5
  } state_t;

endpackage

// File: rtl/addsub_sched_ctrl_shared_addsub.sv
// Single shared adder/subtractor used once per cycle by the scheduled
// controller; results wrap modulo 2^DATAWIDTH.
module shared_addsub #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 op,
  output logic [DATAWIDTH-1:0] y
);

  assign y = op ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_sched_ctrl.sv
// FSMD computing z = (a+b > a+c) ? a+b : a+c and x = (a-b)-c over four
// scheduled steps using one shared add/sub unit and one signed comparator.
module addsub_sched_ctrl
  import addsub_sched_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  output logic                        Busy,
  output logic                        Done,
  output logic signed [DATAWIDTH-1:0] z,
  output logic signed [DATAWIDTH-1:0] x
);

  state_t state, next_state;

  logic signed [DATAWIDTH-1:0] ra, rb, rc;
  logic signed [DATAWIDTH-1:0] d, e, f;
  logic                        g;

  logic [DATAWIDTH-1:0] alu_a, alu_b, alu_y;
  logic                 alu_op;

  shared_addsub #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Operand mux and op select depend only on state; idle states add zeros.
  always_comb begin
    next_state = ST_IDLE;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OP_ADD;
    Busy       = 1'b1;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        Busy       = 1'b0;
        next_state = Start ? ST_S1 : ST_IDLE;
      end
      ST_S1: begin
        alu_a      = ra;
        alu_b      = rb;
        next_state = ST_S2;
      end
      ST_S2: begin
        alu_a      = ra;
        alu_b      = rc;
        next_state = ST_S3;
      end
      ST_S3: begin
        alu_a      = ra;
        alu_b      = rb;
        alu_op     = OP_SUB;
        next_state = ST_S4;
      end
      ST_S4: begin
        alu_a      = f;
        alu_b      = rc;
        alu_op     = OP_SUB;
        next_state = ST_FINAL;
      end
      ST_FINAL: begin
        Done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        Busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ra <= '0;
      rb <= '0;
      rc <= '0;
      d  <= '0;
      e  <= '0;
      f  <= '0;
      g  <= 1'b0;
      z  <= '0;
      x  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            ra <= a;
            rb <= b;
            rc <= c;
          end
        end
        ST_S1: d <= alu_y;
        ST_S2: e <= alu_y;
        ST_S3: begin
          f <= alu_y;
          g <= (d > e);
        end
        ST_S4: begin
          x <= alu_y;
          z <= g ? d : e;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sched_ctrl.sv
// Randomized self-checking bench for addsub_sched_ctrl against a plain
// arithmetic reference of the computed function and its cycle timing.
module tb_addsub_sched_ctrl;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [31:0] a, b, c;
  logic        Busy, Done;
  logic [31:0] z, x;

  int numChecks = 0;
  int numErrors = 0;
  logic [31:0] prevZ = 0;
  logic [31:0] prevX = 0;

  addsub_sched_ctrl #(.DATAWIDTH(32)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .a     (a),
    .b     (b),
    .c     (c),
    .Busy  (Busy),
    .Done  (Done),
    .z     (z),
    .x     (x)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic void refModel(input logic [31:0] ia, ib, ic,
                                   output logic [31:0] oz, ox);
    logic [31:0] d, e;
    d  = ia + ib;
    e  = ia + ic;
    oz = ($signed(d) > $signed(e)) ? d : e;
    ox = (ia - ib) - ic;
  endfunction

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // One full computation; optionally hammers Start with junk while busy.
  task automatic applyStimulus(input logic [31:0] ia, ib, ic, input bit noisy);
    logic [31:0] expZ, expX;
    refModel(ia, ib, ic, expZ, expX);
    a = ia; b = ib; c = ic; Start = 1'b1;
    stepCycle();
    checkOutput("busy_accept", Busy, 1);
    checkOutput("done_accept", Done, 0);
    for (int k = 1; k <= 5; k++) begin
      Start = noisy;
      a = noisy ? 32'd100 : $urandom;
      b = $urandom;
      c = $urandom;
      stepCycle();
      checkOutput("busy_run", Busy, (k != 5) ? 1 : 0);
      if (k == 4) begin
        checkOutput("done_pulse", Done, 1);
        checkOutput("z_result", z, expZ);
        checkOutput("x_result", x, expX);
        prevZ = expZ;
        prevX = expX;
      end else begin
        checkOutput("done_low", Done, 0);
        checkOutput("z_hold", z, prevZ);
        checkOutput("x_hold", x, prevX);
      end
    end
    Start = 1'b0;
    stepCycle();
    checkOutput("busy_no_requeue", Busy, 0);
    checkOutput("done_no_second", Done, 0);
  endtask

  initial begin
    logic [31:0] qa[$], qb[$], qc[$];
    logic [31:0] expZ, expX;

    Rst = 1'b1; Start = 1'b0; a = 0; b = 0; c = 0;
    #12;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_x", x, 0);
    @(negedge Clk);
    Rst = 1'b0;
    #4;

    applyStimulus(32'd5, 32'd3, 32'd10, 1'b0);
    applyStimulus(32'd10, 32'd7, 32'd1, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0);
    applyStimulus(32'd1, 32'd2, 32'd3, 1'b1);
    checkOutput("busy_z_val", z, 32'd4);
    checkOutput("busy_x_val", x, 32'hFFFFFFFC);

    // Abort a computation while it sits in S3.
    a = 32'd5; b = 32'd3; c = 32'd10; Start = 1'b1;
    stepCycle();
    Start = 1'b0;
    stepCycle();
    stepCycle();
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_done", Done, 0);
    checkOutput("abort_z", z, 0);
    checkOutput("abort_x", x, 0);
    prevZ = 0;
    prevX = 0;
    @(negedge Clk);
    Rst = 1'b0;
    #4;
    applyStimulus(32'd10, 32'd7, 32'd1, 1'b0);

    for (int i = 0; i < 20; i++)
      applyStimulus($urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0));

    // Start held high: acceptances every 6 edges, inputs change every cycle.
    Start = 1'b1;
    for (int t = 0; t < 24; t++) begin
      a = $urandom; b = $urandom; c = $urandom;
      if (t % 6 == 0) begin
        qa.push_back(a); qb.push_back(b); qc.push_back(c);
      end
      stepCycle();
      checkOutput("b2b_busy", Busy, (t % 6 != 5) ? 1 : 0);
      if (t % 6 == 4) begin
        refModel(qa.pop_front(), qb.pop_front(), qc.pop_front(), expZ, expX);
        checkOutput("b2b_done", Done, 1);
        checkOutput("b2b_z", z, expZ);
        checkOutput("b2b_x", x, expX);
        prevZ = expZ;
        prevX = expX;
      end else begin
        checkOutput("b2b_done_low", Done, 0);
        checkOutput("b2b_z_hold", z, prevZ);
        checkOutput("b2b_x_hold", x, prevX);
      end
    end
    Start = 1'b0;
    stepCycle();
    checkOutput("b2b_idle", Busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
